// File: rtl/snake_pkg.sv
// Shared direction encoding and helpers for the snake direction controller.
package snake_pkg;

    localparam int unsigned DIR_BITS       = 3;
    localparam int unsigned BTN_PER_PLAYER = 4;

    typedef enum logic [DIR_BITS-1:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_RIGHT = 3'd2,
        DIR_DOWN  = 3'd3,
        DIR_LEFT  = 3'd4
    } dir_t;

    localparam dir_t RESET_DIR = DIR_RIGHT;

    function automatic dir_t dir_opposite(input dir_t d);
        case (d)
            DIR_UP:    return DIR_DOWN;
            DIR_DOWN:  return DIR_UP;
            DIR_RIGHT: return DIR_LEFT;
            DIR_LEFT:  return DIR_RIGHT;
            default:   return DIR_NONE;
        endcase
    endfunction

    // Press vector is {left,down,right,up}; up wins, left loses.
    function automatic dir_t pick_candidate(input logic [BTN_PER_PLAYER-1:0] press);
        if (press[0]) return DIR_UP;
        if (press[1]) return DIR_RIGHT;
        if (press[2]) return DIR_DOWN;
        if (press[3]) return DIR_LEFT;
        return DIR_NONE;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter for one active-low button.
// press_c flags the cycle whose clock edge moves the stable level from released to pressed.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic clock,
    input  logic resetn,
    input  logic raw_n,
    output logic press_c
);

    logic             sync_a;
    logic             synced;
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic             at_limit;

    assign at_limit = (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_a <= 1'b1;
            synced <= 1'b1;
            stable <= 1'b1;
            cnt    <= '0;
        end else begin
            sync_a <= raw_n;
            synced <= sync_a;
            if (synced == stable) begin
                cnt <= '0;
            end else if (at_limit) begin
                stable <= synced;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign press_c = stable & ~synced & at_limit;

endmodule

// File: rtl/snake_dir_ctrl.sv
// N-player direction controller: debounced buttons, reversal filter, turn buffer.
// Define DIR_QUEUE_EN for a 2-entry turn FIFO per player; default is a single overwrite slot.
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned N_PLAYERS       = 2,
    parameter int unsigned DIR_W           = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic                           game_tick,
    input  logic                           game_reset,
    input  logic [4*N_PLAYERS-1:0]         btn_n,
    output logic [N_PLAYERS*DIR_W-1:0]     dir,
    output logic [N_PLAYERS-1:0]           dir_changed,
    output logic [N_PLAYERS-1:0]           turn_rejected,
    output logic [N_PLAYERS-1:0]           pending_valid
);

    localparam int unsigned N_BTN = BTN_PER_PLAYER * N_PLAYERS;

    logic [N_BTN-1:0] press_c;

    for (genvar b = 0; b < N_BTN; b++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clock  (clock),
            .resetn (resetn),
            .raw_n  (btn_n[b]),
            .press_c(press_c[b])
        );
    end

    for (genvar p = 0; p < N_PLAYERS; p++) begin : g_player
        dir_t dir_q;
        dir_t cand;
        dir_t ref_dir;
        logic legal;
        logic pop;
        logic chg;
        logic rej;

        assign cand  = pick_candidate(press_c[BTN_PER_PLAYER*p +: BTN_PER_PLAYER]);
        assign legal = (cand != DIR_NONE) && (cand != ref_dir) && (cand != dir_opposite(ref_dir));

        assign dir[DIR_W*p +: DIR_W] = DIR_W'(dir_q);
        assign dir_changed[p]        = chg;
        assign turn_rejected[p]      = rej;

`ifdef DIR_QUEUE_EN
        dir_t q0;
        dir_t q1;
        logic v0;
        logic v1;
        logic v0_pop;
        logic v1_pop;
        logic push;

        // Occupancy after the tick's pop decides where (and whether) the candidate lands.
        assign ref_dir = v1 ? q1 : (v0 ? q0 : dir_q);
        assign pop     = game_tick & v0;
        assign v0_pop  = pop ? v1 : v0;
        assign v1_pop  = ~pop & v1;
        assign push    = legal & ~v1_pop;

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                dir_q <= RESET_DIR;
                q0    <= DIR_NONE;
                q1    <= DIR_NONE;
                v0    <= 1'b0;
                v1    <= 1'b0;
                chg   <= 1'b0;
                rej   <= 1'b0;
            end else if (game_reset) begin
                dir_q <= RESET_DIR;
                v0    <= 1'b0;
                v1    <= 1'b0;
                chg   <= 1'b0;
                rej   <= 1'b0;
            end else begin
                chg <= pop;
                rej <= (cand != DIR_NONE) & ~push;
                v0  <= v0_pop | push;
                v1  <= v1_pop | (push & v0_pop);
                if (pop) begin
                    dir_q <= q0;
                    q0    <= q1;
                end
                if (push) begin
                    if (v0_pop) q1 <= cand;
                    else        q0 <= cand;
                end
            end
        end

        assign pending_valid[p] = v0;
`else
        dir_t slot;
        logic slot_v;

        assign ref_dir = slot_v ? slot : dir_q;
        assign pop     = game_tick & slot_v;

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                dir_q  <= RESET_DIR;
                slot   <= DIR_NONE;
                slot_v <= 1'b0;
                chg    <= 1'b0;
                rej    <= 1'b0;
            end else if (game_reset) begin
                dir_q  <= RESET_DIR;
                slot_v <= 1'b0;
                chg    <= 1'b0;
                rej    <= 1'b0;
            end else begin
                chg    <= pop;
                rej    <= (cand != DIR_NONE) & ~legal;
                slot_v <= (slot_v & ~pop) | legal;
                if (pop)   dir_q <= slot;
                if (legal) slot  <= cand;
            end
        end

        assign pending_valid[p] = slot_v;
`endif
    end

endmodule
